// File: rtl/sync_memory.sv
// Single-port synchronous word memory: per-byte write enables, registered read with QValid strobe.
// Define MEMORY_CLEAR_EN to build the hardware clear sequencer (CLEAR/IDLE FSM, Busy, Clear input).
module sync_memory #(
    parameter int WordSize        = 32,
    parameter int WordsNumberLog2 = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Clear,
    input  logic                       Valid,
    input  logic                       Status,
    input  logic [WordsNumberLog2-1:0] Address,
    input  logic [WordSize/8-1:0]      ByteEnable,
    input  logic [WordSize-1:0]        I,
    output logic                       Ready,
    output logic                       Busy,
    output logic [WordSize-1:0]        Q,
    output logic                       QValid,
    output logic                       dbg_state
);

    localparam int ByteLanes = WordSize / 8;
    localparam int Depth     = 2 ** WordsNumberLog2;

    // Handshake: a request is taken on a rising edge only when Valid && Ready;
    // Ready depends on state/Clear/Reset only, never on Valid. Refused requests vanish.

    logic [WordSize-1:0]        mem_q [Depth];
    logic [WordSize-1:0]        q_q, q_d;
    logic                       q_valid_q, q_valid_d;
    logic                       mem_we;
    logic [WordsNumberLog2-1:0] mem_addr;
    logic [WordSize-1:0]        mem_wdata;
    logic [ByteLanes-1:0]       mem_be;

`ifdef MEMORY_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [WordsNumberLog2-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Busy      = (state_q == ST_CLEAR);
    assign dbg_state = state_q;
`else
    logic unused_clear;

    assign unused_clear = Clear;
    assign Busy         = 1'b0;
    assign dbg_state    = 1'b0;
`endif

    always_comb begin
        q_d       = q_q;
        q_valid_d = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = Address;
        mem_wdata = I;
        mem_be    = ByteEnable;
`ifdef MEMORY_CLEAR_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        Ready   = (state_q == ST_IDLE) && !Clear && !Reset;
        if (!Reset && state_q == ST_CLEAR) begin
            // Sweep one word per edge; leave after writing the last address.
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == {WordsNumberLog2{1'b1}}) begin
                state_d = ST_IDLE;
            end
        end else if (!Reset && Clear) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end
`else
        Ready = !Reset;
`endif
        if (Valid && Ready) begin
            if (Status) begin
                mem_we = 1'b1;
            end else begin
                q_d       = mem_q[Address];
                q_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // Storage array is deliberately not reset; only the clear sequencer zeroes it.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            for (int b = 0; b < ByteLanes; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign Q      = q_q;
    assign QValid = q_valid_q;

endmodule

// File: doc/sync_memory.md
# sync_memory

Parametrised single-port synchronous word memory with per-byte write enables, a registered read port with a valid strobe, and a hardware clear sequencer that zeroes the whole array after reset or on request. It replaces the plain write/read memory in the datapath, serving as instruction/data storage for the RISC-V datapath. A request/ready handshake lets upstream logic stall while the array is being cleared.

## Interface
- WordSize, 32, bits per word; must be a multiple of 8
- WordsNumberLog2, 4, address width; depth = 2^WordsNumberLog2
- ByteLanes, WordSize/8, derived; not overridden
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- Clear  in  1  request a full-array clear (level sampled at each edge)
- Valid  in  1  request strobe
- Status  in  1  1 = write, 0 = read (qualified by Valid)
- Address  in  WordsNumberLog2  word address
- ByteEnable  in  ByteLanes  write lane mask; bit n covers I[8n+7:8n]
- I  in  WordSize  write data
- Ready  out  1  request accepted this cycle if Valid
- Busy  out  1  clear sequence in progress
- Q  out  WordSize  read data, registered
- QValid  out  1  one-cycle pulse: Q holds new read data

## Operation
- States: CLEAR, IDLE. Counter Cnt, WordsNumberLog2 bits.
- Reset=1 at an edge: state <= CLEAR, Cnt <= 0, Q <= 0, QValid <= 0; no array write while Reset held.
- CLEAR: each edge writes 0 to word Cnt, Cnt <= Cnt+1; edge with Cnt = 2^WordsNumberLog2-1 writes last word, state <= IDLE. Clear input ignored in CLEAR.
- IDLE, Clear=1: state <= CLEAR, Cnt <= 0; any simultaneous Valid request dropped (Clear wins).
- Ready = (state == IDLE) && !Clear && !Reset. Busy = (state == CLEAR).
- Accepted write (Valid && Ready && Status): lanes with ByteEnable=1 take I bytes; other lanes unchanged. ByteEnable=0 → no change, still accepted.
- Accepted read (Valid && Ready && !Status): Q <= mem[Address], QValid <= 1.
- Otherwise QValid <= 0; Q holds last value.
- Requests with Ready=0 are discarded; no queuing, no side effects.
- Address fully decoded; no out-of-range case.

## Timing
- Reset outputs (after reset edge): Q=0, QValid=0, Ready=0, Busy=1.
- Clear duration: exactly 2^WordsNumberLog2 edges after the first edge with Reset=0 (or after the edge sampling Clear); Ready=1 from the following cycle.
- Read latency 1: read accepted at edge k → Q/QValid valid after edge k+1... precisely, updated at edge k, visible in cycle k+1.
- Write visible to a read accepted at the next edge (write-then-read back-to-back returns new data).
- Reset mid-clear: Cnt restarts at 0; full sequence repeats.
- Reset with pending read: QValid forced 0 at that edge.
- Throughput: one request per cycle in IDLE.

## Configuration
- MEMORY_CLEAR_EN defined: clear sequencer, CLEAR state, Busy behaviour as above.
- Undefined: no sequencer; Reset only clears Q/QValid, array contents untouched; Busy tied 0; Clear ignored; Ready = !Reset; Ready=1 in the cycle after reset.

## Test plan
(WordSize=32, WordsNumberLog2=4, MEMORY_CLEAR_EN defined unless stated)
- Reset 1 cycle, then release → Busy=1 for 16 cycles, Ready=0 throughout; read addr 5 afterward → Q=0x00000000, QValid pulse of 1 cycle.
- Write addr 3 I=0x11223344 ByteEnable=4'b1111, then read addr 3 next cycle → Q=0x11223344 one cycle after read accepted.
- Write addr 3 I=0xAABBCCDD ByteEnable=4'b0101, read addr 3 → Q=0x11BB33DD.
- Clear=1 together with Valid write addr 7 I=0xFFFFFFFF → write dropped, Busy 16 cycles, then reads of addr 3 and addr 7 → 0x00000000.
- Reset asserted when Cnt=9 during clear, held 2 cycles → Busy stays 1, 16 further clear cycles after release; Valid reads during Busy → QValid never pulses, array unchanged.
- MEMORY_CLEAR_EN undefined: write addr 2 = 0x5, Reset, read addr 2 → Ready=1 the cycle after reset, Busy=0, Q=0x00000005.
